// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - BCD up/down counter with load/clear and pipelined digit scanner
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_scan_counter #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic                  iEn,
   input  logic                  iUp,
   input  logic                  iLoad,
   input  logic [4*DIGITS-1:0]   iLoadVal,
   input  logic                  iClear,
   output logic [4*DIGITS-1:0]   oBcd,
   output logic                  oCarry,
   output logic [3:0]            oDigit,
   output logic [DIGITS-1:0]     oSel
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PW-1:0]       presc;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       idx_d;
   logic                sel_valid;
   logic [4*DIGITS-1:0] step_val;
   logic [4*DIGITS-1:0] load_val;
   logic                step_wrap;
   logic                ripple;
   logic [3:0]          cur_digit;
   logic [DIGITS-1:0]   sel_n;

   // Ripple carry/borrow through the digits; a ripple left over past the top digit is a wrap.
   always_comb begin
      logic [3:0] digit;
      step_val = oBcd;
      ripple   = 1'b1;
      digit    = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         digit = oBcd[4*i +: 4];
         if (ripple) begin
            if (iUp) begin
               if (digit == 4'd9) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = digit + 4'd1;
                  ripple = 1'b0;
               end
            end else begin
               if (digit == 4'd0) begin
                  step_val[4*i +: 4] = 4'd9;
               end else begin
                  step_val[4*i +: 4] = digit - 4'd1;
                  ripple = 1'b0;
               end
            end
         end
      end
      step_wrap = ripple;
   end

   always_comb begin
      load_val = '0;
      for (int i = 0; i < DIGITS; i++) begin
         load_val[4*i +: 4] = (iLoadVal[4*i +: 4] > 4'd9) ? 4'd0 : iLoadVal[4*i +: 4];
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      sel_n     = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) cur_digit = oBcd[4*i +: 4];
         if (idx_d == IW'(i)) sel_n[i] = 1'b0;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic              blank_d;
   logic              blank_now;
   logic [DIGITS-1:0] upper_zero;

   // upper_zero[i]: digit i and every digit above it are zero.
   always_comb begin
      logic zacc;
      zacc       = 1'b1;
      upper_zero = '0;
      blank_now  = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zacc          = zacc & (oBcd[4*i +: 4] == 4'd0);
         upper_zero[i] = zacc;
      end
      for (int i = 1; i < DIGITS; i++) begin
         if (idx == IW'(i)) blank_now = upper_zero[i];
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) blank_d <= 1'b0;
      else         blank_d <= blank_now;
   end
`else
   logic blank_d;
   assign blank_d = 1'b0;
`endif

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         oBcd   <= '0;
         oCarry <= 1'b0;
      end else if (iClear) begin
         oBcd   <= '0;
         oCarry <= 1'b0;
      end else if (iLoad) begin
         oBcd   <= load_val;
         oCarry <= 1'b0;
      end else if (iEn) begin
         oBcd   <= step_val;
         oCarry <= step_wrap;
      end else begin
         oCarry <= 1'b0;
      end
   end

   // sel_valid keeps oSel dark until the index delay register holds a real sample.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         presc     <= '0;
         idx       <= '0;
         idx_d     <= '0;
         sel_valid <= 1'b0;
         oDigit    <= 4'd0;
         oSel      <= '1;
      end else begin
         if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
         oDigit    <= cur_digit;
         idx_d     <= idx;
         sel_valid <= 1'b1;
         oSel      <= (sel_valid && !blank_d) ? sel_n : '1;
      end
   end

endmodule
